andchain_stim_gen: RTL
======================

// Module: andchain_stim_gen
// PURPOSE
//   Stimulus transmitter for the AndChain spec lanes: generates the a_i/b_i/c_i
//   input traces consumed by the spec0..specN-1 instances and flags valid cycles.
//   Sits beside the AndChain top in the trace-generation bench; one start produces
//   a TRACE_LEN-sample trace in random (LFSR) or deterministic walking-chain form.
// PARAMETERS
//   N_LANES    5     number of spec lanes (width of a/b/c); 1..5
//   TRACE_LEN  1024  samples emitted per run; >= 1
//   CNT_W      16    width of sample_cnt; 2**CNT_W > TRACE_LEN
// PORTS
//   clk         in   1         single clock, all flops rising edge
//   rst_n       in   1         asynchronous active-low reset
//   start       in   1         pulse: begin a run (ignored unless IDLE)
//   abort       in   1         terminate current run next edge
//   mode        in   2         0 random, 1 walking-chain, 2 all-ones, 3 all-zeros
//   seed        in   16        LFSR seed, sampled on accepted start
//   a           out  N_LANES   lane a inputs (a[i] -> a_i)
//   b           out  N_LANES   lane b inputs
//   c           out  N_LANES   lane c inputs
//   valid       out  1         a/b/c carry a trace sample this cycle
//   busy        out  1         run in progress (LOAD or RUN)
//   done        out  1         one-cycle pulse at run completion or abort
//   sample_cnt  out  CNT_W     samples emitted in current/last run
// BEHAVIOUR
//   Reset: state IDLE; a=b=c=0, valid=0, busy=0, done=0, sample_cnt=0, lfsr=16'hACE1.
//   FSM IDLE -> LOAD (start) -> RUN -> DONE -> IDLE.
//   - IDLE: outputs a/b/c=0, valid=0. On start: latch mode and seed, clear sample_cnt.
//   - LOAD: one cycle; lfsr <= (seed==0) ? 16'hACE1 : seed; phase <= 0; busy=1.
//   - RUN: each cycle emits one sample, valid=1, sample_cnt++; when sample_cnt
//     reaches TRACE_LEN-1 in this cycle, next state DONE. Latency start->first valid = 2.
//   - DONE: one cycle, done=1, valid=0, a/b/c=0; sample_cnt holds TRACE_LEN.
//   Sample content (registered, valid with the same edge):
//   - mode0: Galois LFSR x^16+x^14+x^13+x^11+1 (shift right, xor 16'hB400 when lsb=1),
//     advanced every RUN cycle; a[i]=lfsr[i], b[i]=lfsr[i+5], c[i]=lfsr[i+10] of pre-advance value.
//   - mode1: 2-bit phase counter p wraps 3->0 each RUN cycle; lane i uses q=(p+i)%4:
//     q0 a=1; q1 a=b=1; q2 a=b=c=1; q3 all 0.
//   - mode2: a=b=c=all ones; mode3: all zeros (valid still 1).
//   mode/seed changes while busy are ignored until next start.
//   abort: in LOAD or RUN -> DONE next edge (done=1, sample_cnt frozen at count so far);
//     abort in IDLE/DONE ignored; abort has priority over normal completion.
//   start while busy or in DONE: ignored (no restart, no counter clear).
//   start and abort same cycle in IDLE: start wins (abort ignored in IDLE).
//   rst_n low mid-run: immediate return to reset values; no done pulse.
//   sample_cnt never wraps: TRACE_LEN < 2**CNT_W enforced by elaboration check.
// TESTING
//   1. Reset, mode=1, start, TRACE_LEN=8 -> valid high cycles 2..9; lane0 a/b/c seq
//      100,110,111,000,100,...; lane1 leads by one phase; done at cycle 10; sample_cnt=8.
//   2. mode=0, seed=16'h0001 -> first sample a=5'b00001, b=0, c=0; second lfsr=16'hB400,
//      c=5'b01101 (bits 10..14); 1024 samples then done, sample_cnt=1024.
//   3. mode=0, seed=0 -> trace identical to seed=16'hACE1 run.
//   4. Abort after 3 valid samples -> done next cycle, sample_cnt=3, then IDLE, a/b/c=0.
//   5. start pulsed during RUN and during DONE -> ignored; run length unchanged.
//   6. rst_n low at sample 5 of mode2 run -> outputs 0 asynchronously, no done;
//      new start after release runs a full TRACE_LEN trace.

Source files
------------

// File: rtl/andchain_stim_gen.sv
// Stimulus transmitter for the AndChain spec lanes: drives a/b/c traces of TRACE_LEN
// samples per start, in LFSR-random, walking-chain, all-ones or all-zeros form.
module andchain_stim_gen #(
    parameter int unsigned N_LANES   = 5,
    parameter int unsigned TRACE_LEN = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [1:0]         mode_i,
    input  logic [15:0]        seed_i,
    output logic [N_LANES-1:0] a_o,
    output logic [N_LANES-1:0] b_o,
    output logic [N_LANES-1:0] c_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   sample_cnt_o
);

    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_INIT = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TRACE_LEN - 1);

    if (N_LANES == 0 || N_LANES > 5 || TRACE_LEN == 0 ||
        64'(TRACE_LEN) >= (64'd1 << CNT_W)) begin : g_param_chk
        $error("andchain_stim_gen: illegal N_LANES/TRACE_LEN/CNT_W combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {M_RAND, M_WALK, M_ONES, M_ZERO} mode_e;

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [LFSR_W-1:0]    seed_q, seed_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [1:0]           phase_q, phase_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_LANES-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic                 valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic                 emit;
    logic [LFSR_W-1:0]    src_lfsr;
    logic [1:0]           src_phase;
    logic [N_LANES-1:0]   walk_a, walk_b, walk_c;

    // The sample leaving LOAD comes straight from the (zero-protected) seed and phase 0.
    assign src_lfsr  = (state_q == S_LOAD) ? ((seed_q == '0) ? LFSR_INIT : seed_q) : lfsr_q;
    assign src_phase = (state_q == S_LOAD) ? 2'd0 : phase_q;

    for (genvar g = 0; g < N_LANES; g++) begin : g_walk
        logic [1:0] lane_ph;
        assign lane_ph   = src_phase + 2'(g);
        assign walk_a[g] = (lane_ph != 2'd3);
        assign walk_b[g] = (lane_ph == 2'd1) || (lane_ph == 2'd2);
        assign walk_c[g] = (lane_ph == 2'd2);
    end

    // Next state; registered outputs describe the state being entered.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        a_d     = '0;
        b_d     = '0;
        c_d     = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        emit    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    mode_d  = mode_e'(mode_i);
                    seed_d  = seed_i;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    emit    = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (abort_i || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    emit   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (emit) begin
            valid_d = 1'b1;
            lfsr_d  = (src_lfsr >> 1) ^ (src_lfsr[0] ? LFSR_TAPS : '0);
            phase_d = src_phase + 2'd1;
            unique case (mode_q)
                M_RAND: begin
                    a_d = src_lfsr[N_LANES-1:0];
                    b_d = src_lfsr[N_LANES+4:5];
                    c_d = src_lfsr[N_LANES+9:10];
                end
                M_WALK: begin
                    a_d = walk_a;
                    b_d = walk_b;
                    c_d = walk_c;
                end
                M_ONES: begin
                    a_d = '1;
                    b_d = '1;
                    c_d = '1;
                end
                default: begin
                    a_d = '0;
                    b_d = '0;
                    c_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_RAND;
            seed_q  <= '0;
            lfsr_q  <= LFSR_INIT;
            phase_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_o          = a_q;
    assign b_o          = b_q;
    assign c_o          = c_q;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sample_cnt_o = cnt_q;

endmodule
